// File: rtl/run_ctrl_dump.sv
// run_ctrl_dump: gates sccomp execution, halts on PC/budget/self-loop, then streams the register file out.
module run_ctrl_dump #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CW = 16,
  parameter int LOOP_N = 4,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [XLEN-1:0] halt_pc,
  input  logic [CW-1:0]   max_cycles,
  input  logic [XLEN-1:0] pc,
  output logic            cpu_run,
  output logic [RW-1:0]   reg_sel,
  input  logic [XLEN-1:0] reg_data,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [XLEN-1:0] dump_data,
  output logic [RW-1:0]   dump_idx,
  output logic            dump_last,
  output logic            done,
  output logic [1:0]      cause,
  output logic [CW-1:0]   cycles
);
  localparam int LW = $clog2(LOOP_N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
  state_t state, state_n;
  logic [RW:0] idx;
  logic [LW-1:0] loop_cnt;
  logic [XLEN-1:0] pc_prev;
  logic hit_pc, hit_bud, hit_loop, hit, load, fire, arm;
  always_comb begin
    hit_pc = pc == halt_pc;
    hit_bud = max_cycles != '0 && cycles == max_cycles;
    hit_loop = loop_cnt == LW'(LOOP_N - 1) && pc == pc_prev;
    hit = hit_pc || hit_bud || hit_loop;
    cpu_run = state == RUN && !hit;
    arm = (state == IDLE || state == DONE) && start;
    load = state == DUMP && (!dump_valid || dump_ready) && idx < (RW+1)'(NREG);
    fire = dump_valid && dump_ready && dump_last;
    state_n = state;
    if (arm) state_n = RUN;
    else if (state == RUN && hit) state_n = DUMP;
    else if (state == DUMP && fire) state_n = DONE;
    reg_sel = idx[RW-1:0];
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx <= '0;
      loop_cnt <= '0;
      pc_prev <= '0;
      cycles <= '0;
      cause <= '0;
      dump_valid <= 1'b0;
      dump_data <= '0;
      dump_idx <= '0;
      dump_last <= 1'b0;
    end else begin
      state <= state_n;
      if (arm) begin
        cycles <= '0;
        cause <= '0;
        loop_cnt <= '0;
        idx <= '0;
      end
      if (state == RUN) begin
        pc_prev <= pc;
        loop_cnt <= pc == pc_prev ? loop_cnt + 1'b1 : '0;
        if (hit) cause <= hit_pc ? 2'd1 : hit_loop ? 2'd3 : 2'd2;
      end
      if (cpu_run && !(&cycles)) cycles <= cycles + 1'b1;
      // The last word's acceptance leaves idx at NREG, so no load competes with the clear.
      if (load) begin
        dump_data <= idx == '0 ? '0 : reg_data;
        dump_idx <= idx[RW-1:0];
        dump_last <= idx == (RW+1)'(NREG - 1);
        dump_valid <= 1'b1;
        idx <= idx + 1'b1;
      end else if (dump_valid && dump_ready) begin
        dump_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_run_ctrl_dump.sv
// tb_run_ctrl_dump: drives run_ctrl_dump against a tiny behavioural CPU and scoreboards the register dump.
module tb_run_ctrl_dump;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [31:0] halt_pc = '0;
  logic [15:0] max_cycles = '0;
  logic [31:0] pc;
  logic cpu_run;
  logic [4:0] reg_sel;
  logic [31:0] reg_data;
  logic dump_valid;
  logic dump_ready = 1'b0;
  logic [31:0] dump_data;
  logic [4:0] dump_idx;
  logic dump_last, done;
  logic [1:0] cause;
  logic [15:0] cycles;
  int tests = 0;
  int fails = 0;
  int mode = 0;
  logic model_rst = 1'b1;
  logic [31:0] rf [32];

  typedef struct packed {logic [4:0] idx; logic [31:0] data; logic last;} word_t;
  word_t q[$];

  always #5 clk = ~clk;

  run_ctrl_dump dut (
    .clk(clk), .rstn(rstn), .start(start), .halt_pc(halt_pc), .max_cycles(max_cycles),
    .pc(pc), .cpu_run(cpu_run), .reg_sel(reg_sel), .reg_data(reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .dump_last(dump_last), .done(done), .cause(cause), .cycles(cycles)
  );

  assign reg_data = rf[reg_sel];

  // mode 0: straight line, instr k writes x(k+1)=0x100+k; mode 1: two-instr loop bumping x7;
  // mode 2: straight line up to 0x20, then jal x0,0 at 0x20.
  always @(posedge clk) begin
    if (model_rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA000 + i;
    end else if (cpu_run) begin
      if (mode == 1) begin
        rf[7] <= rf[7] + 1;
        pc <= pc == 32'h4 ? 32'h0 : 32'h4;
      end else if (mode == 2 && pc >= 32'h20) begin
        pc <= pc;
      end else begin
        if (pc[31:2] < 31) rf[pc[6:2] + 5'd1] <= 32'h100 + {2'b00, pc[31:2]};
        pc <= pc + 4;
      end
    end
  end

  function automatic logic [31:0] exp_word(int m, int n, int i);
    if (i == 0) return 32'h0;
    if (m == 1) return i == 7 ? 32'hA007 + n : 32'hA000 + i;
    return (i >= 1 && i <= n) ? 32'h100 + i - 1 : 32'hA000 + i;
  endfunction

  task automatic check_reset_values(input string name);
    tests++;
    if ({cpu_run, reg_sel, dump_valid, dump_data, dump_idx, dump_last, done, cause, cycles} !== '0) begin
      fails++;
      $display("FAIL %s: outputs cpu_run=%b reg_sel=%0d valid=%b data=%h idx=%0d last=%b done=%b cause=%0d cycles=%0d, required all 0",
               name, cpu_run, reg_sel, dump_valid, dump_data, dump_idx, dump_last, done, cause, cycles);
    end
  endtask

  task automatic run_dump(input string name, input int m, input logic [31:0] hpc, input logic [15:0] maxc,
                          input logic [31:0] epc, input logic [1:0] ecause, input logic [15:0] ecyc,
                          input int nwr, input bit bp, input bit abort, input bit poke);
    bit halted = 0;
    bit finished = 0;
    int words = 0;
    int n;
    word_t e;
    rstn = 1'b0; model_rst = 1'b1; mode = m; halt_pc = hpc; max_cycles = maxc; dump_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    model_rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (cpu_run !== 1'b1 || cycles !== 16'd0) begin
      fails++;
      $display("FAIL %s start: cpu_run=%b cycles=%0d, required 1 and 0", name, cpu_run, cycles);
    end
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      start = poke && t == 20;
      if (!cpu_run) begin halted = 1; break; end
    end
    start = 1'b0;
    tests++;
    if (!halted) begin
      fails++;
      $display("FAIL %s halt: no halt within 3000 cycles, required a halt", name);
      return;
    end
    tests++;
    if (pc !== epc || cycles !== ecyc) begin
      fails++;
      $display("FAIL %s halt_state: pc=%h cycles=%0d, required pc=%h cycles=%0d", name, pc, cycles, epc, ecyc);
    end
    for (int i = 0; i < 32; i++) begin
      e.idx = i[4:0]; e.data = exp_word(m, nwr, i); e.last = i == 31;
      q.push_back(e);
    end
    @(negedge clk);
    tests++;
    if (cause !== ecause || dump_valid !== 1'b0 || cpu_run !== 1'b0) begin
      fails++;
      $display("FAIL %s dump_entry: cause=%0d valid=%b cpu_run=%b, required cause=%0d valid=0 cpu_run=0",
               name, cause, dump_valid, cpu_run, ecause);
    end
    for (n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      if (done) begin finished = 1; break; end
      if (abort && words == 10) begin
        rstn = 1'b0;
        #1;
        check_reset_values({name, "_async_reset"});
        q.delete();
        return;
      end
      dump_ready = bp ? (n % 4 == 0 || n % 4 == 3) : 1'b1;
      if (dump_valid && dump_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL %s extra_word: idx=%0d data=%h, required no more words", name, dump_idx, dump_data);
        end else begin
          e = q.pop_front();
          if (dump_idx !== e.idx || dump_data !== e.data || dump_last !== e.last) begin
            fails++;
            $display("FAIL %s word: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                     name, dump_idx, dump_data, dump_last, e.idx, e.data, e.last);
          end
        end
        words++;
      end
    end
    dump_ready = 1'b0;
    tests++;
    if (!finished || words != 32 || q.size() != 0) begin
      fails++;
      $display("FAIL %s completion: done_seen=%b words=%0d left=%0d, required 1, 32, 0", name, finished, words, q.size());
    end
    if (!bp) begin
      tests++;
      if (n != 33) begin
        fails++;
        $display("FAIL %s throughput: %0d cycles to done, required 33", name, n);
      end
    end
    tests++;
    if (cause !== ecause || cycles !== ecyc || dump_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s done_hold: cause=%0d cycles=%0d valid=%b, required %0d %0d 0", name, cause, cycles, dump_valid, ecause, ecyc);
    end
    q.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
  endtask

  task automatic test_pc_match;
    run_dump("pc_match", 0, 32'h48, 16'd0, 32'h48, 2'd1, 16'd18, 18, 0, 0, 0);
  endtask

  task automatic test_budget;
    run_dump("budget", 1, 32'hFFFC, 16'd100, 32'h0, 2'd2, 16'd100, 100, 0, 0, 1);
  endtask

  task automatic test_self_loop;
    run_dump("self_loop", 2, 32'hFFFC, 16'd0, 32'h20, 2'd3, 16'd12, 8, 0, 0, 0);
  endtask

  task automatic test_backpressure;
    run_dump("backpressure", 0, 32'h48, 16'd0, 32'h48, 2'd1, 16'd18, 18, 1, 0, 0);
  endtask

  task automatic test_simultaneous;
    run_dump("simultaneous", 0, 32'h28, 16'd10, 32'h28, 2'd1, 16'd10, 10, 0, 0, 0);
  endtask

  task automatic test_reset_mid_dump;
    run_dump("mid_dump", 0, 32'h48, 16'd0, 32'h48, 2'd1, 16'd18, 18, 1, 1, 0);
    run_dump("after_reset", 0, 32'h48, 16'd0, 32'h48, 2'd1, 16'd18, 18, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_pc_match();
    test_budget();
    test_self_loop();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/run_ctrl_dump.md
# run_ctrl_dump

Synthesisable run controller for the single-cycle computer (`sccomp`). It gates CPU execution with a clock enable, counts executed cycles, and halts on one of three conditions: a PC match, a cycle budget, or a self-loop. After halting it walks the register file through the `reg_sel`/`reg_data` debug port and streams each register out over a valid/ready interface. It sits beside `sccomp` at the board or bench top level, so end-of-run register dumps no longer depend on the simulator.

## Interface
Parameters:
- `XLEN`, 32, datapath / PC / register width
- `NREG`, 32, registers dumped (index 0..NREG-1); `RW` = clog2(NREG)
- `CW`, 16, cycle counter width
- `LOOP_N`, 4, consecutive cycles with unchanged PC that declare a self-loop (min 2)

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  reset; asynchronous, active-low
- `start`  in  1  arm the run; honoured in IDLE or DONE only
- `halt_pc`  in  XLEN  stop address; the instruction at this PC is not executed
- `max_cycles`  in  CW  cycle budget; 0 = unlimited
- `pc`  in  XLEN  current CPU PC
- `cpu_run`  out  1  CPU clock enable
- `reg_sel`  out  RW  register index to `sccomp`
- `reg_data`  in  XLEN  `rf[reg_sel]`, combinational from the CPU
- `dump_valid`  out  1  dump word available
- `dump_ready`  in  1  sink accepts the word
- `dump_data`  out  XLEN  register value; index 0 always forced to 0
- `dump_idx`  out  RW  register index of `dump_data`
- `dump_last`  out  1  asserted with index NREG-1
- `done`  out  1  dump complete
- `cause`  out  2  0 none, 1 PC match, 2 budget, 3 self-loop
- `cycles`  out  CW  executed cycle count

## Operation
- **States:** IDLE, RUN, DUMP, DONE.
- **IDLE → RUN** on `start`. Same edge clears `cycles`, `cause`, the loop counter and the dump index.
- **RUN:**
  - hit_pc = (`pc == halt_pc`).
  - hit_bud = (`max_cycles != 0` && `cycles == max_cycles`).
  - hit_loop = (loop counter == LOOP_N-1 && `pc == pc_prev`).
  - `cpu_run = (state==RUN) && !(hit_pc || hit_bud || hit_loop)`. This is combinational, so the halting instruction never executes.
  - `cycles` increments on each edge where `cpu_run` is 1 and saturates at all-ones.
  - Loop counter increments when `pc == pc_prev`, otherwise clears. `pc_prev` is registered every RUN cycle.
  - Any hit → DUMP. `cause` is latched with priority PC match > self-loop > budget.
- **DUMP:**
  - `reg_sel` = internal index `idx`.
  - On an edge where `!dump_valid || (dump_valid && dump_ready)` and `idx < NREG`:
    - capture `dump_data` ← (`idx == 0` ? 0 : `reg_data`), `dump_idx` ← `idx`, `dump_last` ← (`idx == NREG-1`);
    - set `dump_valid` ← 1 and increment `idx`.
  - If `dump_valid && dump_ready && !load`, clear `dump_valid`.
  - Handshake completes on the edge with `dump_valid && dump_ready && dump_last` → DONE, `dump_valid` ← 0.
- **DONE:** `done` = 1. `cause` and `cycles` hold. `start` re-enters RUN and clears `done`. The CPU itself is not reset; the PC continues from where it halted.
- **Held outputs:** `dump_data`, `dump_idx` and `dump_last` are stable while `dump_valid && !dump_ready`.
- **Ignored `start`:** in RUN or DUMP, `start` has no effect.
- **Reset:** asserting `rstn` low at any time, including mid-dump, returns the block to IDLE immediately.

## Timing
- **Reset values:**
  - `cpu_run` = 0, `reg_sel` = 0, `dump_valid` = 0, `dump_data` = 0, `dump_idx` = 0, `dump_last` = 0;
  - `done` = 0, `cause` = 0, `cycles` = 0; state IDLE.
- **Start latency:** `start` sampled at edge N; `cpu_run` is high in cycle N+1.
- **Halt latency:** the halt is detected in the same cycle it occurs. `cpu_run` is low in that cycle, and state is DUMP from the next edge.
- **First dump word:** `dump_valid` rises one edge after entering DUMP.
- **Throughput:** with `dump_ready` held high, one word per cycle. NREG words need NREG+1 cycles from DUMP entry to the first DONE cycle.
- **Budget count:** with budget B (non-zero), exactly B cycles execute, and `cycles` = B at halt.
- **Simultaneous hits:** `cause` takes the highest-priority hit; `cycles` is not incremented on the halting cycle.

## Test plan
- **PC match:** `halt_pc` = 0x48, `max_cycles` = 0, program with 18 straight-line instructions from 0x00 → halt with `pc` = 0x48, `cause` = 1, `cycles` = 18; the instruction at 0x48 has not written the RF.
- **Budget:** infinite counting loop, `max_cycles` = 100 → `cause` = 2, `cycles` = 100; dumped x7 equals the value after exactly 100 instructions.
- **Self-loop:** `jal x0, 0` at 0x20, LOOP_N = 4 → `cause` = 3; the halt occurs 3 cycles after PC first reaches 0x20, counted from the first repeat.
- **Dump backpressure:** `dump_ready` toggling 1,0,0,1,… → 32 words with `dump_idx` 0..31 in order, no loss or duplicate, `dump_data[0]` = 0, `dump_last` only on idx 31, then `done` = 1.
- **Simultaneous hits:** `halt_pc` reached on the same cycle `cycles == max_cycles` → `cause` = 1.
- **Reset mid-dump:** `rstn` low after 10 words → all outputs at reset values immediately; a fresh `start` runs and dumps normally.
